// File: rtl/router_pkg.sv
// Shared definitions for the router output drain: header field layout,
// drain FSM states and the beat record held in the skid buffer.
package router_pkg;

    localparam int LEN_MSB  = 7;
    localparam int LEN_LSB  = 2;
    localparam int ADDR_MSB = 1;
    localparam int BEAT_W   = 11;

    typedef enum logic {
        ST_IDLE,
        ST_BODY
    } state_t;

    typedef struct packed {
        logic       perr;
        logic       eop;
        logic       sop;
        logic [7:0] data;
    } beat_t;

    function automatic logic [LEN_MSB-LEN_LSB:0] hdr_len(input logic [7:0] hdr);
        return hdr[LEN_MSB:LEN_LSB];
    endfunction

    function automatic logic [ADDR_MSB:0] hdr_addr(input logic [7:0] hdr);
        return hdr[ADDR_MSB:0];
    endfunction

endpackage

// File: rtl/router_skid2.sv
// Two-entry skid buffer of beats; the head entry is presented directly
// from storage so the beat outputs are registered.
module router_skid2
    import router_pkg::*;
(
    input  logic       clock,
    input  logic       resetn,
    input  logic       flush,
    input  logic       push,
    input  beat_t      din,
    input  logic       pop,
    output beat_t      head,
    output logic       head_vld,
    output logic [1:0] occ
);

    logic [BEAT_W-1:0] ent0;
    logic [BEAT_W-1:0] ent1;
    logic              do_pop;

    assign do_pop   = pop && (occ != 2'd0);
    assign head     = beat_t'(ent0);
    assign head_vld = (occ != 2'd0);

    // Push into the first free slot; a pop shifts entry 1 forward.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            ent0 <= '0;
            ent1 <= '0;
            occ  <= 2'd0;
        end else if (flush) begin
            ent0 <= '0;
            ent1 <= '0;
            occ  <= 2'd0;
        end else begin
            case ({push, do_pop})
                2'b10: begin
                    if (occ == 2'd0) begin
                        ent0 <= din;
                    end else begin
                        ent1 <= din;
                    end
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    ent0 <= ent1;
                    ent1 <= '0;
                    occ  <= occ - 2'd1;
                end
                2'b11: begin
                    if (occ == 2'd1) begin
                        ent0 <= din;
                    end else begin
                        ent0 <= ent1;
                        ent1 <= din;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/router_out_drain.sv
// Drains one router output FIFO, frames bytes into sop/payload/eop beats,
// checks parity and flushes the FIFO when the destination stalls too long.
module router_out_drain
    import router_pkg::*;
#(
    parameter int TIMEOUT = 30,
    parameter int TO_W    = 5
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_dout,
    output logic       read_enb,
    output logic       soft_reset,
    input  logic       dst_ready,
    output logic [7:0] dout,
    output logic       dout_vld,
    output logic       dout_sop,
    output logic       dout_eop,
    output logic       dout_perr,
    output logic       pkt_dropped
);

    logic            inflight;
    logic [1:0]      occ;
    logic            pop;
    logic            capture;
    logic            stalled;
    logic [2:0]      credit_used;
    beat_t           head;
    beat_t           beat_in;
    state_t          state;
    state_t          state_nxt;
    logic [6:0]      remaining;
    logic [6:0]      remaining_nxt;
    logic [7:0]      acc;
    logic [7:0]      acc_nxt;
    logic [TO_W-1:0] stall_cnt;

    assign pop         = dout_vld && dst_ready;
    assign stalled     = dout_vld && !dst_ready;
    assign capture     = inflight && !soft_reset;
    assign credit_used = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    // Gated by resetn so the strobe is also quiet while reset is held.
    assign read_enb    = resetn && !fifo_empty && !soft_reset && (credit_used < 3'd2);

    assign dout        = head.data;
    assign dout_sop    = head.sop;
    assign dout_eop    = head.eop;
    assign dout_perr   = head.perr;
    assign pkt_dropped = soft_reset;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            inflight <= 1'b0;
        end else begin
            inflight <= read_enb;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state     <= ST_IDLE;
            remaining <= '0;
            acc       <= '0;
        end else if (soft_reset) begin
            state     <= ST_IDLE;
            remaining <= '0;
            acc       <= '0;
        end else begin
            state     <= state_nxt;
            remaining <= remaining_nxt;
            acc       <= acc_nxt;
        end
    end

    // remaining counts bytes still owed after the header, parity included.
    always_comb begin
        state_nxt     = state;
        remaining_nxt = remaining;
        acc_nxt       = acc;
        beat_in       = '0;
        beat_in.data  = fifo_dout;
        if (capture) begin
            case (state)
                ST_IDLE: begin
                    beat_in.sop   = 1'b1;
                    remaining_nxt = {1'b0, hdr_len(fifo_dout)} + 7'd1;
                    acc_nxt       = fifo_dout;
                    state_nxt     = ST_BODY;
                end
                ST_BODY: begin
                    if (remaining == 7'd1) begin
                        beat_in.eop   = 1'b1;
                        beat_in.perr  = (fifo_dout != acc);
                        remaining_nxt = '0;
                        state_nxt     = ST_IDLE;
                    end else begin
                        remaining_nxt = remaining - 7'd1;
                        acc_nxt       = acc ^ fifo_dout;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // The flush pulse fires in the cycle after the TIMEOUT-th stalled cycle.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            stall_cnt  <= '0;
            soft_reset <= 1'b0;
        end else begin
            soft_reset <= !soft_reset && stalled && (stall_cnt == TO_W'(TIMEOUT - 1));
            if (soft_reset || !stalled) begin
                stall_cnt <= '0;
            end else begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end

    router_skid2 u_skid (
        .clock    (clock),
        .resetn   (resetn),
        .flush    (soft_reset),
        .push     (capture),
        .din      (beat_in),
        .pop      (pop),
        .head     (head),
        .head_vld (dout_vld),
        .occ      (occ)
    );

endmodule

// File: tb/tb_router_out_drain.sv
// Scoreboard bench for router_out_drain: a FIFO model feeds bytes, a packet-level
// reference model predicts beats, and a monitor checks every accepted beat.
module tb_router_out_drain;

    localparam int TIMEOUT = 30;

    typedef struct {
        logic [7:0] data;
        logic       sop;
        logic       eop;
        logic       perr;
    } exp_t;

    logic       clock;
    logic       resetn;
    logic       fifo_empty;
    logic [7:0] fifo_dout;
    logic       read_enb;
    logic       soft_reset;
    logic       dst_ready;
    logic [7:0] dout;
    logic       dout_vld;
    logic       dout_sop;
    logic       dout_eop;
    logic       dout_perr;
    logic       pkt_dropped;

    exp_t       exp_q[$];
    logic [7:0] fifo_q[$];
    logic [7:0] pkt[$];

    int checks        = 0;
    int errors        = 0;
    int cyc           = 0;
    int ready_mode    = 0;
    int expect_drop   = 0;
    int drop_seen     = 0;
    int outstanding   = 0;
    int stall_run     = 0;
    int first_vld_cyc = -1;
    int first_pop_cyc = -1;
    int last_pop_cyc  = -1;
    int pop_count     = 0;

    router_out_drain #(.TIMEOUT(TIMEOUT), .TO_W(5)) dut (
        .clock       (clock),
        .resetn      (resetn),
        .fifo_empty  (fifo_empty),
        .fifo_dout   (fifo_dout),
        .read_enb    (read_enb),
        .soft_reset  (soft_reset),
        .dst_ready   (dst_ready),
        .dout        (dout),
        .dout_vld    (dout_vld),
        .dout_sop    (dout_sop),
        .dout_eop    (dout_eop),
        .dout_perr   (dout_perr),
        .pkt_dropped (pkt_dropped)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        forever begin
            @(posedge clock);
            cyc++;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0h expected=%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Reference model: frame the staged packet from its header length field.
    task automatic applyStimulus();
        logic [7:0] parity;
        int         len;
        exp_t       e;
        len    = int'(pkt[0][7:2]);
        parity = pkt[0];
        for (int i = 0; i < len + 2; i++) begin
            e.data = pkt[i];
            e.sop  = (i == 0);
            e.eop  = (i == len + 1);
            e.perr = 1'b0;
            if (e.eop) begin
                e.perr = (pkt[i] != parity);
            end else if (i > 0) begin
                parity = parity ^ pkt[i];
            end
            exp_q.push_back(e);
            fifo_q.push_back(pkt[i]);
        end
    endtask

    task automatic waitIdle(input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!(exp_q.size() == 0 && fifo_q.size() == 0 && !dout_vld) && n < budget);
        checkOutput("drain_pending", 32'(exp_q.size() + fifo_q.size() + int'(dout_vld)), 32'd0);
    endtask

    task automatic measureLatency();
        int n;
        int fall_cyc;
        n = 0;
        fall_cyc = -1;
        do begin
            @(negedge clock);
            n++;
            if (!fifo_empty) fall_cyc = cyc;
        end while (fall_cyc < 0 && n < 20);
        n = 0;
        while (first_vld_cyc < 0 && n < 20) begin
            @(negedge clock);
            n++;
        end
        checkOutput("first_vld_latency", 32'(first_vld_cyc - fall_cyc), 32'd2);
    endtask

    task automatic clearMarks();
        first_vld_cyc = -1;
        first_pop_cyc = -1;
        last_pop_cyc  = -1;
        pop_count     = 0;
    endtask

    // FIFO model: data appears the cycle after read_enb; flushed by soft_reset.
    initial begin
        logic re;
        logic sr;
        fifo_dout  = 8'h00;
        fifo_empty = 1'b1;
        forever begin
            @(negedge clock);
            re = read_enb;
            sr = soft_reset;
            @(posedge clock);
            #1;
            if (re && fifo_q.size() > 0) fifo_dout = fifo_q.pop_front();
            else fifo_dout = 8'h00;
            if (sr) fifo_q.delete();
            fifo_empty = (fifo_q.size() == 0);
        end
    end

    initial begin
        int phase;
        phase = 0;
        dst_ready = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            case (ready_mode)
                0: dst_ready = 1'b1;
                1: begin
                    dst_ready = (phase == 0);
                    phase = (phase + 1) % 3;
                end
                2: dst_ready = 1'b0;
                default: dst_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    initial begin
        exp_t        e;
        logic [31:0] prev_val;
        logic        prev_stall;
        logic        post_drop;
        prev_val   = '0;
        prev_stall = 1'b0;
        post_drop  = 1'b0;
        forever begin
            @(negedge clock);
            if (!resetn) begin
                prev_stall  = 1'b0;
                post_drop   = 1'b0;
                outstanding = 0;
                stall_run   = 0;
                continue;
            end
            if (post_drop) begin
                checkOutput("post_drop_state", 32'({soft_reset, pkt_dropped, dout_vld}), 32'd0);
                post_drop = 1'b0;
            end
            if (prev_stall) begin
                checkOutput("stall_hold", 32'({dout_vld, dout_sop, dout_eop, dout_perr, dout}), prev_val);
            end
            if (dout_vld && first_vld_cyc < 0) first_vld_cyc = cyc;
            if (soft_reset) begin
                checkOutput("drop_expected", 32'(expect_drop), 32'd1);
                checkOutput("drop_stall_len", 32'(stall_run), 32'(TIMEOUT));
                checkOutput("drop_pulse", 32'({pkt_dropped, read_enb}), 32'h2);
                exp_q.delete();
                drop_seen   = 1;
                post_drop   = 1'b1;
                stall_run   = 0;
                outstanding = 0;
                prev_stall  = 1'b0;
            end else begin
                if (dout_vld && dst_ready) begin
                    if (exp_q.size() == 0) begin
                        checkOutput("beat_unexpected", 32'({dout_sop, dout_eop, dout_perr, dout}), 32'h7ff);
                    end else begin
                        e = exp_q.pop_front();
                        checkOutput("beat", 32'({dout_sop, dout_eop, dout_perr, dout}),
                                    32'({e.sop, e.eop, e.perr, e.data}));
                    end
                    if (first_pop_cyc < 0) first_pop_cyc = cyc;
                    last_pop_cyc = cyc;
                    pop_count++;
                end
                outstanding = outstanding + int'(read_enb) - int'(dout_vld && dst_ready);
                if (read_enb) checkOutput("read_credit", 32'(outstanding <= 2), 32'd1);
                stall_run  = (dout_vld && !dst_ready) ? stall_run + 1 : 0;
                prev_stall = dout_vld && !dst_ready;
                prev_val   = 32'({dout_vld, dout_sop, dout_eop, dout_perr, dout});
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int         n;
        int         len;
        logic [7:0] b;
        logic [7:0] par;
        resetn = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        checkOutput("reset_state", 32'({read_enb, soft_reset, dout, dout_vld, dout_sop,
                                        dout_eop, dout_perr, pkt_dropped}), 32'd0);
        @(posedge clock);
        #3 resetn = 1'b1;

        $display("[TB] single packet, good parity");
        @(posedge clock); #2;
        clearMarks();
        pkt = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D};
        applyStimulus();
        measureLatency();
        waitIdle(200);
        checkOutput("t1_beat_span", 32'(last_pop_cyc - first_pop_cyc), 32'd4);

        $display("[TB] single packet, bad parity");
        @(posedge clock); #2;
        pkt = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0C};
        applyStimulus();
        waitIdle(200);

        $display("[TB] backpressure pattern");
        @(posedge clock); #2;
        ready_mode = 1;
        pkt = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D};
        applyStimulus();
        waitIdle(300);
        ready_mode = 0;

        $display("[TB] stall timeout");
        @(posedge clock); #2;
        ready_mode  = 2;
        expect_drop = 1;
        drop_seen   = 0;
        pkt = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D};
        applyStimulus();
        n = 0;
        while (drop_seen == 0 && n < 100) begin
            @(negedge clock);
            n++;
        end
        checkOutput("t4_drop_seen", 32'(drop_seen), 32'd1);
        repeat (3) @(posedge clock);
        #2;
        expect_drop = 0;
        ready_mode  = 0;
        clearMarks();
        pkt = '{8'h05, 8'hAA, 8'hAF};
        applyStimulus();
        waitIdle(200);
        checkOutput("t4_after_drop_beats", 32'(pop_count), 32'd3);

        $display("[TB] back-to-back packets");
        @(posedge clock); #2;
        clearMarks();
        pkt = '{8'h00, 8'h00};
        applyStimulus();
        pkt = '{8'h04, 8'h7E, 8'h7A};
        applyStimulus();
        waitIdle(200);
        checkOutput("t5_beat_span", 32'(last_pop_cyc - first_pop_cyc), 32'd4);

        $display("[TB] asynchronous reset mid-packet");
        @(posedge clock); #2;
        clearMarks();
        pkt = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D};
        applyStimulus();
        n = 0;
        while (pop_count < 2 && n < 50) begin
            @(negedge clock);
            n++;
        end
        checkOutput("t6_mid_packet", 32'(pop_count), 32'd2);
        @(posedge clock);
        #3 resetn = 1'b0;
        #1;
        checkOutput("t6_reset_outputs", 32'({read_enb, soft_reset, dout, dout_vld, dout_sop,
                                             dout_eop, dout_perr, pkt_dropped}), 32'd0);
        exp_q.delete();
        fifo_q.delete();
        repeat (3) @(posedge clock);
        #3 resetn = 1'b1;
        repeat (2) @(posedge clock);
        #2;
        clearMarks();
        pkt = '{8'h05, 8'hAA, 8'hAF};
        applyStimulus();
        waitIdle(200);
        checkOutput("t6_after_reset_beats", 32'(pop_count), 32'd3);

        $display("[TB] randomized packets with random backpressure");
        @(posedge clock); #2;
        ready_mode = 3;
        for (int p = 0; p < 20; p++) begin
            pkt.delete();
            len = $urandom_range(0, 12);
            b   = 8'((len << 2) | int'($urandom_range(0, 3)));
            par = b;
            pkt.push_back(b);
            for (int i = 0; i < len; i++) begin
                b   = 8'($urandom);
                par = par ^ b;
                pkt.push_back(b);
            end
            if ($urandom_range(0, 3) == 0) par = par ^ 8'($urandom_range(1, 255));
            pkt.push_back(par);
            applyStimulus();
        end
        waitIdle(5000);
        ready_mode = 0;

        repeat (2) @(posedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
